// File: rtl/chacha_pkg.sv
// Shared constants, types and helpers for the iterative ChaCha block core.
// Word-index tables drive the column/diagonal operand routing.
package chacha_pkg;

    typedef logic [15:0][31:0] chacha_state_t;
    typedef logic [3:0]        word_idx_t;

    localparam logic [31:0] CHACHA_SIGMA [0:3] = '{
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574
    };

    // Quarter-round lane q operates on words {a, b, c, d} = TABLE[q][0..3]
    localparam word_idx_t COL_IDX [0:3][0:3] = '{
        '{4'd0, 4'd4, 4'd8,  4'd12},
        '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14},
        '{4'd3, 4'd7, 4'd11, 4'd15}
    };

    localparam word_idx_t DIAG_IDX [0:3][0:3] = '{
        '{4'd0, 4'd5, 4'd10, 4'd15},
        '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13},
        '{4'd3, 4'd4, 4'd9,  4'd14}
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_OUT   = 2'd3
    } chacha_core_state_e;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        rotl32 = (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] add32(input logic [31:0] x, input logic [31:0] y);
        add32 = x + y;
    endfunction

endpackage

// File: rtl/chacha_block_core_if.sv
// Request/keystream handshake bundle of the ChaCha block core.
// master = requester/consumer side, slave = the core.
interface chacha_block_core_if;
    import chacha_pkg::*;

    logic          start_valid;
    logic          start_ready;
    logic [255:0]  key;
    logic [95:0]   nonce;
    logic [31:0]   counter;
    logic          ks_valid;
    logic          ks_ready;
    chacha_state_t ks_data;
    logic          busy;

    modport master (
        output start_valid, key, nonce, counter, ks_ready,
        input  start_ready, ks_valid, ks_data, busy
    );

    modport slave (
        input  start_valid, key, nonce, counter, ks_ready,
        output start_ready, ks_valid, ks_data, busy
    );

endinterface

// File: rtl/chacha_quarter_round.sv
// Combinational ChaCha quarter-round on four 32-bit words.
module chacha_quarter_round
    import chacha_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    output logic [31:0] a_new,
    output logic [31:0] b_new,
    output logic [31:0] c_new,
    output logic [31:0] d_new
);

    logic [31:0] a1_s, b1_s, c1_s, d1_s;
    logic [31:0] a2_s, b2_s, c2_s, d2_s;

    // ARX chain: add, xor, rotate by 16/12/8/7
    always_comb begin
        a1_s = add32(a, b);
        d1_s = rotl32(d ^ a1_s, 5'd16);
        c1_s = add32(c, d1_s);
        b1_s = rotl32(b ^ c1_s, 5'd12);
        a2_s = add32(a1_s, b1_s);
        d2_s = rotl32(d1_s ^ a2_s, 5'd8);
        c2_s = add32(c1_s, d2_s);
        b2_s = rotl32(b1_s ^ c2_s, 5'd7);
    end

    assign a_new = a2_s;
    assign b_new = b2_s;
    assign c_new = c2_s;
    assign d_new = d2_s;

endmodule

// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function: one column or diagonal round per clock,
// followed by the feed-forward add and a valid/ready keystream output.
module chacha_block_core
    import chacha_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ROUNDS = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    chacha_block_core_if.slave   bus
);

    localparam int                CNT_W    = $clog2(ROUNDS);
    localparam logic [CNT_W-1:0]  LAST_RND = CNT_W'(ROUNDS - 1);

    if (WIDTH != 32 || ROUNDS < 2 || (ROUNDS % 2) != 0) begin : g_bad_cfg
        $error("chacha_block_core: unsupported WIDTH/ROUNDS configuration");
    end

    chacha_core_state_e state_r, state_next_s;
    chacha_state_t      init_r, init_next_s;
    chacha_state_t      work_r, work_next_s;
    chacha_state_t      ks_data_r, ks_data_next_s;
    chacha_state_t      load_s, round_out_s, final_sum_s;
    logic [CNT_W-1:0]   rnd_cnt_r, rnd_next_s;
    logic               ks_valid_r, ks_valid_next_s;
    logic               start_ready_r, start_ready_next_s;
    logic               busy_r, busy_next_s;

    word_idx_t          sel_idx_s [0:3][0:3];
    logic [31:0]        qr_in_s   [0:3][0:3];
    logic [31:0]        qr_out_s  [0:3][0:3];

    // Even rounds route columns, odd rounds route diagonals into the four lanes
    always_comb begin
        for (int q = 0; q < 4; q++) begin
            for (int k = 0; k < 4; k++) begin
                if (rnd_cnt_r[0]) begin
                    sel_idx_s[q][k] = DIAG_IDX[q][k];
                end else begin
                    sel_idx_s[q][k] = COL_IDX[q][k];
                end
                qr_in_s[q][k] = work_r[sel_idx_s[q][k]];
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_qr
        chacha_quarter_round u_qr (
            .a     (qr_in_s[g][0]),
            .b     (qr_in_s[g][1]),
            .c     (qr_in_s[g][2]),
            .d     (qr_in_s[g][3]),
            .a_new (qr_out_s[g][0]),
            .b_new (qr_out_s[g][1]),
            .c_new (qr_out_s[g][2]),
            .d_new (qr_out_s[g][3])
        );
    end

    // Write lane results back to the word positions they were read from
    always_comb begin
        round_out_s = work_r;
        for (int q = 0; q < 4; q++) begin
            for (int k = 0; k < 4; k++) begin
                round_out_s[sel_idx_s[q][k]] = qr_out_s[q][k];
            end
        end
    end

    // Initial state assembled from constants and the request fields
    always_comb begin
        load_s = '0;
        for (int i = 0; i < 4; i++) begin
            load_s[i] = CHACHA_SIGMA[i];
        end
        for (int i = 0; i < 8; i++) begin
            load_s[4 + i] = bus.key[32*i +: 32];
        end
        load_s[12] = bus.counter;
        for (int i = 0; i < 3; i++) begin
            load_s[13 + i] = bus.nonce[32*i +: 32];
        end
    end

    // Per-word feed-forward add; words never carry into each other
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            final_sum_s[i] = add32(work_r[i], init_r[i]);
        end
    end

    // Next-state and next-output logic of the control FSM
    always_comb begin
        state_next_s    = state_r;
        init_next_s     = init_r;
        work_next_s     = work_r;
        rnd_next_s      = rnd_cnt_r;
        ks_data_next_s  = ks_data_r;
        ks_valid_next_s = ks_valid_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start_valid) begin
                    init_next_s  = load_s;
                    work_next_s  = load_s;
                    rnd_next_s   = '0;
                    state_next_s = ST_ROUND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ROUND: begin
                work_next_s = round_out_s;
                if (rnd_cnt_r == LAST_RND) begin
                    state_next_s = ST_FINAL;
                end else begin
                    rnd_next_s = rnd_cnt_r + 1'b1;
                end
            end
            ST_FINAL: begin
                ks_data_next_s  = final_sum_s;
                ks_valid_next_s = 1'b1;
                state_next_s    = ST_OUT;
            end
            ST_OUT: begin
                if (bus.ks_ready) begin
                    ks_valid_next_s = 1'b0;
                    state_next_s    = ST_IDLE;
                end else begin
                    ks_valid_next_s = 1'b1;
                end
            end
            default: begin
                ks_valid_next_s = 1'b0;
                state_next_s    = ST_IDLE;
            end
        endcase
        start_ready_next_s = (state_next_s == ST_IDLE);
        busy_next_s        = (state_next_s != ST_IDLE);
    end

    // State and output registers; reset aborts any block in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            init_r        <= '0;
            work_r        <= '0;
            rnd_cnt_r     <= '0;
            ks_data_r     <= '0;
            ks_valid_r    <= 1'b0;
            start_ready_r <= 1'b1;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            init_r        <= init_next_s;
            work_r        <= work_next_s;
            rnd_cnt_r     <= rnd_next_s;
            ks_data_r     <= ks_data_next_s;
            ks_valid_r    <= ks_valid_next_s;
            start_ready_r <= start_ready_next_s;
            busy_r        <= busy_next_s;
        end
    end

    assign bus.start_ready = start_ready_r;
    assign bus.ks_valid    = ks_valid_r;
    assign bus.ks_data     = ks_data_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_chacha_block_core.sv
// Directed bench for chacha_block_core: RFC 8439 vectors, backpressure,
// mid-operation reset, back-to-back blocks, counter wrap and a ChaCha8 build.
module tb_chacha_block_core;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    int   guard;
    logic bp_ok;

    chacha_block_core_if bus ();
    chacha_block_core_if bus8 ();

    chacha_block_core #(.WIDTH(32), .ROUNDS(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    chacha_block_core #(.WIDTH(32), .ROUNDS(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    always #5 clk = ~clk;

    localparam logic [511:0] RFC232 = {
        32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
        32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
        32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
        32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110
    };
    localparam logic [511:0] A11 = {
        32'h8665eeb2, 32'h69b687c3, 32'h1ca11815, 32'hf4b8436a,
        32'h374ad8b8, 32'h3fe02477, 32'h8d485751, 32'h7c5941da,
        32'hc70d778b, 32'hccef36a8, 32'h1aed8da0, 32'hb819d2bd,
        32'h28bd8653, 32'he56a5d40, 32'h903df1a0, 32'hade0b876
    };
    localparam logic [95:0] N232 = {32'h00000000, 32'h4a000000, 32'h09000000};

    logic [255:0] k232;
    logic [511:0] exp_blk;

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [511:0] qr_m(input logic [511:0] st, input int ia, input int ib,
                                          input int ic, input int id);
        logic [31:0] a, b, c, d;
        a = st[32*ia +: 32]; b = st[32*ib +: 32]; c = st[32*ic +: 32]; d = st[32*id +: 32];
        a = a + b; d = rl(d ^ a, 16);
        c = c + d; b = rl(b ^ c, 12);
        a = a + b; d = rl(d ^ a, 8);
        c = c + d; b = rl(b ^ c, 7);
        st[32*ia +: 32] = a; st[32*ib +: 32] = b; st[32*ic +: 32] = c; st[32*id +: 32] = d;
        return st;
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                               input logic [31:0] c, input int rounds);
        logic [511:0] s0, x;
        s0 = {n, c, k, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
        x  = s0;
        for (int r = 0; r < rounds / 2; r++) begin
            x = qr_m(x, 0, 4, 8, 12);  x = qr_m(x, 1, 5, 9, 13);
            x = qr_m(x, 2, 6, 10, 14); x = qr_m(x, 3, 7, 11, 15);
            x = qr_m(x, 0, 5, 10, 15); x = qr_m(x, 1, 6, 11, 12);
            x = qr_m(x, 2, 7, 8, 13);  x = qr_m(x, 3, 4, 9, 14);
        end
        for (int i = 0; i < 16; i++) begin
            x[32*i +: 32] = x[32*i +: 32] + s0[32*i +: 32];
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start20(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
        int g;
        bus.key = k; bus.nonce = n; bus.counter = c; bus.start_valid = 1'b1;
        g = 0;
        while (bus.start_ready !== 1'b1 && g < 100) begin tick(); g++; end
        chk("start_ready_wait", 512'(bus.start_ready), 512'(1));
        tick();
        bus.start_valid = 1'b0;
    endtask

    task automatic wait_ks(output int n);
        n = 0;
        while (bus.ks_valid !== 1'b1 && n < 200) begin tick(); n++; end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; checks = 0; failures = 0;
        for (int i = 0; i < 32; i++) k232[8*i +: 8] = 8'(i);
        bus.start_valid = 1'b0; bus.key = '0; bus.nonce = '0; bus.counter = '0; bus.ks_ready = 1'b0;
        bus8.start_valid = 1'b0; bus8.key = '0; bus8.nonce = '0; bus8.counter = '0; bus8.ks_ready = 1'b0;

        tick(); tick();
        chk("rst_start_ready", 512'(bus.start_ready), 512'(1));
        chk("rst_ks_valid", 512'(bus.ks_valid), 512'(0));
        chk("rst_ks_data", 512'(bus.ks_data), 512'(0));
        chk("rst_busy", 512'(bus.busy), 512'(0));
        rst_n = 1'b1;
        tick();

        // RFC 2.3.2 with ks_ready already high before the block exists
        bus.ks_ready = 1'b1;
        start20(k232, N232, 32'd1);
        chk("rfc232_busy", 512'(bus.busy), 512'(1));
        chk("rfc232_no_ready", 512'(bus.start_ready), 512'(0));
        wait_ks(cyc);
        chk("rfc232_latency", 512'(cyc), 512'(21));
        chk("rfc232_word0", 512'(bus.ks_data[0]), 512'(32'he4e7f110));
        chk("rfc232_word1", 512'(bus.ks_data[1]), 512'(32'h15593bd1));
        chk("rfc232_block", 512'(bus.ks_data), RFC232);
        tick();
        chk("rfc232_valid_drop", 512'(bus.ks_valid), 512'(0));
        chk("rfc232_idle_ready", 512'(bus.start_ready), 512'(1));
        chk("rfc232_data_hold", 512'(bus.ks_data), RFC232);

        // RFC A.1 #1 then 50 clocks of backpressure with a competing request
        bus.ks_ready = 1'b0;
        start20('0, '0, 32'd0);
        wait_ks(cyc);
        chk("a11_latency", 512'(cyc), 512'(21));
        chk("a11_word0", 512'(bus.ks_data[0]), 512'(32'hade0b876));
        chk("a11_word1", 512'(bus.ks_data[1]), 512'(32'h903df1a0));
        chk("a11_block", 512'(bus.ks_data), A11);
        bus.key = k232; bus.counter = 32'd5; bus.start_valid = 1'b1;
        bp_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.ks_data !== A11 || bus.ks_valid !== 1'b1 || bus.start_ready !== 1'b0) bp_ok = 1'b0;
        end
        chk("bp_stable", 512'(bp_ok), 512'(1));
        bus.start_valid = 1'b0;
        bus.ks_ready = 1'b1;
        tick();
        chk("bp_release_valid", 512'(bus.ks_valid), 512'(0));
        chk("bp_release_ready", 512'(bus.start_ready), 512'(1));
        chk("bp_release_busy", 512'(bus.busy), 512'(0));
        chk("bp_release_hold", 512'(bus.ks_data), A11);

        // Asynchronous reset at rnd_cnt = 7
        bus.ks_ready = 1'b0;
        start20('0, '0, 32'd0);
        for (int i = 0; i < 7; i++) tick();
        chk("midrst_busy_before", 512'(bus.busy), 512'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_ks_valid", 512'(bus.ks_valid), 512'(0));
        chk("midrst_busy", 512'(bus.busy), 512'(0));
        chk("midrst_ks_data", 512'(bus.ks_data), 512'(0));
        chk("midrst_start_ready", 512'(bus.start_ready), 512'(1));
        tick();
        rst_n = 1'b1;
        tick();
        bus.ks_ready = 1'b1;
        start20(k232, N232, 32'd1);
        wait_ks(cyc);
        chk("midrst_recover_word0", 512'(bus.ks_data[0]), 512'(32'he4e7f110));
        chk("midrst_recover_block", 512'(bus.ks_data), RFC232);
        tick();

        // Back-to-back counters 1 and 2, inputs scrambled while rounds run
        bus.key = k232; bus.nonce = N232; bus.counter = 32'd1; bus.start_valid = 1'b1;
        guard = 0;
        while (bus.start_ready !== 1'b1 && guard < 100) begin tick(); guard++; end
        tick();
        for (int i = 0; i < 12; i++) begin
            for (int w = 0; w < 8; w++) bus.key[32*w +: 32] = $urandom();
            for (int w = 0; w < 3; w++) bus.nonce[32*w +: 32] = $urandom();
            bus.counter = $urandom();
            tick();
        end
        bus.key = k232; bus.nonce = N232; bus.counter = 32'd2;
        wait_ks(cyc);
        chk("b2b_first_latency", 512'(cyc + 12), 512'(21));
        chk("b2b_first_block", 512'(bus.ks_data), RFC232);
        tick();
        chk("b2b_idle_ready", 512'(bus.start_ready), 512'(1));
        tick();
        bus.start_valid = 1'b0;
        chk("b2b_second_busy", 512'(bus.busy), 512'(1));
        wait_ks(cyc);
        chk("b2b_second_latency", 512'(cyc), 512'(21));
        exp_blk = ref_block(k232, N232, 32'd2, 20);
        chk("b2b_second_block", 512'(bus.ks_data), exp_blk);
        tick();

        // Counter 0xFFFFFFFF is used as given
        start20('0, '0, 32'hffffffff);
        wait_ks(cyc);
        exp_blk = ref_block('0, '0, 32'hffffffff, 20);
        chk("wrap_block", 512'(bus.ks_data), exp_blk);
        tick();

        // ChaCha8 instance
        bus8.ks_ready = 1'b1;
        bus8.key = k232; bus8.nonce = N232; bus8.counter = 32'd1; bus8.start_valid = 1'b1;
        guard = 0;
        while (bus8.start_ready !== 1'b1 && guard < 100) begin tick(); guard++; end
        tick();
        bus8.start_valid = 1'b0;
        cyc = 0;
        while (bus8.ks_valid !== 1'b1 && cyc < 200) begin tick(); cyc++; end
        chk("chacha8_latency", 512'(cyc), 512'(9));
        exp_blk = ref_block(k232, N232, 32'd1, 8);
        chk("chacha8_block", 512'(bus8.ks_data), exp_blk);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
